mem_request_master: RTL

//  Initiator side of the main-memory port (rd_mem/wr_mem/addr_mem/data_in/data_out/ready_mem).

---
 rtl/mem_request_master.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_request_master.sv
// mem_request_master
//   Initiator side of the main-memory port. Takes single-beat or burst
//   read/write commands from a client and issues one memory strobe per beat.
//   It holds each strobe for HOLD_CYCLES and then waits in RECOV until
//   ready_mem returns high. Read beats come back on rd_data/rd_valid.
//
//   Optional feature: define MEM_REQ_TIMEOUT_EN to bound the RECOV wait to
//   TIMEOUT_CYCLES cycles. On expiry it sets the sticky err flag, drops the
//   remaining beats and completes the burst. Without the macro err is tied 0.
//
//   Handshakes (strict valid/ready):
//     a transfer happens on a posedge where valid & ready are both high.
//     valid never waits on ready; ready is a pure function of state
//     (cmd_ready = IDLE, wr_ready = WDAT).
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_we, cmd_addr, cmd_len
//                         give direction, first address and beats-1
//   wr_data/wr_valid/     write beat handshake
//   wr_ready
//   rd_data/rd_valid      registered read beat, one-cycle pulse, no backpressure
//   busy, done, err       status: not idle, burst end pulse, sticky timeout
//   rd_mem, wr_mem,       registered memory strobes, address and write data
//   addr_mem, data_in
//   data_out, ready_mem   memory read data and idle indication
//   state_dbg             current FSM state (IDLE=0, WDAT=1, STRB=2, RECOV=3)

module mem_request_master #(
  parameter int AWIDTH         = 9,
  parameter int DWIDTH         = 32,
  parameter int LWIDTH         = 4,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [LWIDTH-1:0] cmd_len,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [AWIDTH-1:0] addr_mem,
  output logic [DWIDTH-1:0] data_in,
  input  logic [DWIDTH-1:0] data_out,
  input  logic              ready_mem,
  output logic [1:0]        state_dbg
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WDAT = 2'd1, STRB = 2'd2, RECOV = 2'd3} state_t;

  state_t            state_q, state_n;
  logic [HW-1:0]     hold_q, hold_n;
  logic [LWIDTH-1:0] beats_q, beats_n;
  logic              we_q, we_n;
  logic              rd_mem_n, wr_mem_n, rd_valid_n, done_n;
  logic [AWIDTH-1:0] addr_n;
  logic [DWIDTH-1:0] din_n, rdata_n;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_n;
  logic          err_q, err_n;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WDAT);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_n    = state_q;
    hold_n     = hold_q;
    beats_n    = beats_q;
    we_n       = we_q;
    rd_mem_n   = rd_mem;
    wr_mem_n   = wr_mem;
    addr_n     = addr_mem;
    din_n      = data_in;
    rdata_n    = rd_data;
    rd_valid_n = 1'b0;
    done_n     = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    tcnt_n     = tcnt_q;
    err_n      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_n    = cmd_we;
          addr_n  = cmd_addr;
          beats_n = cmd_len;
`ifdef MEM_REQ_TIMEOUT_EN
          err_n   = 1'b0;
`endif
          if (cmd_we) begin
            state_n = WDAT;
          end else begin
            state_n  = STRB;
            rd_mem_n = 1'b1;
            hold_n   = HW'(HOLD_CYCLES - 1);
          end
        end
      end
      WDAT: begin
        // Strobe and data register together so memory sees both on the
        // same following negedge.
        if (wr_valid) begin
          din_n    = wr_data;
          wr_mem_n = 1'b1;
          hold_n   = HW'(HOLD_CYCLES - 1);
          state_n  = STRB;
        end
      end
      STRB: begin
        if (hold_q == '0) begin
          rd_mem_n = 1'b0;
          wr_mem_n = 1'b0;
          state_n  = RECOV;
`ifdef MEM_REQ_TIMEOUT_EN
          tcnt_n   = '0;
`endif
        end else begin
          hold_n = hold_q - HW'(1);
        end
      end
      RECOV: begin
        if (ready_mem) begin
          if (!we_q) begin
            rdata_n    = data_out;
            rd_valid_n = 1'b1;
          end
          if (beats_q != '0) begin
            beats_n = beats_q - LWIDTH'(1);
            addr_n  = addr_mem + AWIDTH'(1);  // wraps at 2^AWIDTH
            if (we_q) begin
              state_n = WDAT;
            end else begin
              state_n  = STRB;
              rd_mem_n = 1'b1;
              hold_n   = HW'(HOLD_CYCLES - 1);
            end
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
`ifdef MEM_REQ_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt_q + TW'(1);
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      beats_q  <= '0;
      we_q     <= 1'b0;
      rd_mem   <= 1'b0;
      wr_mem   <= 1'b0;
      addr_mem <= '0;
      data_in  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
      tcnt_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      hold_q   <= hold_n;
      beats_q  <= beats_n;
      we_q     <= we_n;
      rd_mem   <= rd_mem_n;
      wr_mem   <= wr_mem_n;
      addr_mem <= addr_n;
      data_in  <= din_n;
      rd_data  <= rdata_n;
      rd_valid <= rd_valid_n;
      done     <= done_n;
`ifdef MEM_REQ_TIMEOUT_EN
      tcnt_q   <= tcnt_n;
      err_q    <= err_n;
`endif
    end
  end

endmodule
